// File: rtl/bitwise_stream_if.sv
// Stream bundle between operand producer, bitwise_stream_unit and result consumer.
// Valid/ready: a transfer happens on a rising clk edge where valid and ready are
// both 1; a source holding valid keeps its payload stable until that edge, and
// ready may depend combinationally on the payload (in_last) but never on valid.
interface bitwise_stream_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ror;
    logic             out_rand;
    logic             out_rxor;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    // Producer/consumer side
    modport master (
        output in_valid, in_op, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ror, out_rand, out_rxor, out_count, out_ovf
    );

    // Unit side
    modport slave (
        input  in_valid, in_op, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ror, out_rand, out_rxor, out_count, out_ovf
    );
endinterface

// File: rtl/bitwise_stream_unit.sv
// Registered bit-wise operator with multi-beat fold packets.
// Single ops produce one result per beat; fold ops accumulate (A&B) across the
// beats of a packet and emit one result with the beat count on the last beat.
module bitwise_stream_unit #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    bitwise_stream_if.slave       bus,
    output logic                  state_dbg
);
    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] acc, acc_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             ovf, ovf_nx;
    logic [1:0]       fold_op, fold_op_nx;

    logic             out_valid_r, out_valid_nx;
    logic [WIDTH-1:0] out_data_r, out_data_nx;
    logic [CNT_W-1:0] out_count_r, out_count_nx;
    logic             out_ovf_r, out_ovf_nx;

    logic [WIDTH-1:0] ab;
    logic [WIDTH-1:0] single_res;
    logic [WIDTH-1:0] folded;
    logic [CNT_W-1:0] cnt_up;
    logic             sat;
    logic             out_free;
    logic             ready;
    logic             accept;
    logic             is_fold_op;

    // Operand decode, fold arithmetic and handshake qualification
    always_comb begin
        ab         = bus.in_a & bus.in_b;
        is_fold_op = bus.in_op[2] && (bus.in_op != 3'b111);
        case (bus.in_op)
            3'b000:  single_res = bus.in_a & bus.in_b;
            3'b001:  single_res = bus.in_a | bus.in_b;
            3'b010:  single_res = bus.in_a ^ bus.in_b;
            3'b011:  single_res = ~(bus.in_a & bus.in_b);
            default: single_res = bus.in_a;
        endcase
        case (fold_op)
            2'b00:   folded = acc & ab;
            2'b01:   folded = acc | ab;
            default: folded = acc ^ ab;
        endcase
        sat      = (cnt == CNT_W'(MAX_BEATS));
        cnt_up   = sat ? cnt : cnt + CNT_W'(1);
        out_free = !out_valid_r || bus.out_ready;
        // Non-last beats inside a packet never touch the output register.
        if (state == ACCUM && !bus.in_last) ready = !rst;
        else                                ready = !rst && out_free;
        accept = bus.in_valid && ready;
    end

    // Next-state and next-output selection for the fold FSM
    always_comb begin
        state_nx     = state;
        acc_nx       = acc;
        cnt_nx       = cnt;
        ovf_nx       = ovf;
        fold_op_nx   = fold_op;
        out_valid_nx = out_valid_r && !bus.out_ready;
        out_data_nx  = out_data_r;
        out_count_nx = out_count_r;
        out_ovf_nx   = out_ovf_r;
        if (accept) begin
            if (state == IDLE) begin
                if (is_fold_op) begin
                    if (bus.in_last) begin
                        out_valid_nx = 1'b1;
                        out_data_nx  = ab;
                        out_count_nx = CNT_W'(1);
                        out_ovf_nx   = 1'b0;
                    end else begin
                        acc_nx     = ab;
                        cnt_nx     = CNT_W'(1);
                        ovf_nx     = 1'b0;
                        fold_op_nx = bus.in_op[1:0];
                        state_nx   = ACCUM;
                    end
                end else begin
                    out_valid_nx = 1'b1;
                    out_data_nx  = single_res;
                    out_count_nx = CNT_W'(1);
                    out_ovf_nx   = 1'b0;
                end
            end else begin
                // Any op arriving mid-packet is folded under the latched op.
                acc_nx = folded;
                cnt_nx = cnt_up;
                ovf_nx = ovf || sat;
                if (bus.in_last) begin
                    out_valid_nx = 1'b1;
                    out_data_nx  = folded;
                    out_count_nx = cnt_up;
                    out_ovf_nx   = ovf || sat;
                    state_nx     = IDLE;
                end
            end
        end
    end

    // State, accumulator and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            fold_op     <= 2'b00;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_count_r <= '0;
            out_ovf_r   <= 1'b0;
        end else begin
            state       <= state_nx;
            acc         <= acc_nx;
            cnt         <= cnt_nx;
            ovf         <= ovf_nx;
            fold_op     <= fold_op_nx;
            out_valid_r <= out_valid_nx;
            out_data_r  <= out_data_nx;
            out_count_r <= out_count_nx;
            out_ovf_r   <= out_ovf_nx;
        end
    end

    // Output drive; reductions follow the registered data
    always_comb begin
        bus.in_ready  = ready;
        bus.out_valid = out_valid_r;
        bus.out_data  = out_data_r;
        bus.out_count = out_count_r;
        bus.out_ovf   = out_ovf_r;
        bus.out_ror   = |out_data_r;
        bus.out_rand  = &out_data_r;
        bus.out_rxor  = ^out_data_r;
        state_dbg     = (state == ACCUM);
    end
endmodule
